// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet fields, node addresses, packet kind and PE FSM state types
package noc_pkg;

    localparam int KIND_BIT  = 46;
    localparam int DEST_HI   = 45;
    localparam int DEST_LO   = 43;
    localparam int SRC_HI    = 42;
    localparam int SRC_LO    = 40;
    localparam int PAYLOAD_W = 40;

    localparam logic [2:0] ADDR_PE0 = 3'b011;
    localparam logic [2:0] ADDR_PE1 = 3'b001;
    localparam logic [2:0] ADDR_PE2 = 3'b000;
    localparam logic [2:0] ADDR_MEM = 3'b110;

    typedef enum logic {
        PKT_FILTER = 1'b0,
        PKT_PIXEL  = 1'b1
    } pkt_kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/pe_mac3.sv
// rtl/pe_mac3.sv - combinational 3-tap unsigned multiply-add; PE_PSUM_CLIP_EN saturates the sum to one pixel
module pe_mac3 #(
    parameter int DWIDTH = 8,
    parameter int SUM_W  = 2 * DWIDTH + 2
) (
    input  logic [DWIDTH-1:0] p0,
    input  logic [DWIDTH-1:0] p1,
    input  logic [DWIDTH-1:0] p2,
    input  logic [DWIDTH-1:0] f0,
    input  logic [DWIDTH-1:0] f1,
    input  logic [DWIDTH-1:0] f2,
    output logic [SUM_W-1:0]  sum
);

    logic [SUM_W-1:0] raw;

    // Widening to SUM_W before multiplying keeps all three products and the carry.
    assign raw = (SUM_W'(p0) * SUM_W'(f0))
               + (SUM_W'(p1) * SUM_W'(f1))
               + (SUM_W'(p2) * SUM_W'(f2));

`ifdef PE_PSUM_CLIP_EN
    localparam logic [SUM_W-1:0] CLIP_MAX = SUM_W'((1 << DWIDTH) - 1);
    assign sum = (raw > CLIP_MAX) ? CLIP_MAX : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/pe_noc_endpoint.sv
// rtl/pe_noc_endpoint.sv - PE NoC endpoint: filter latch, 5-pixel row 3-tap convolution, result packets (PE_PSUM_CLIP_EN clips psum)
module pe_noc_endpoint
    import noc_pkg::*;
#(
    parameter int                DWIDTH    = 8,
    parameter int                PWIDTH    = 47,
    parameter int                ADDR_W    = 3,
    parameter logic [ADDR_W-1:0] MY_ADDR   = ADDR_PE0,
    parameter logic [ADDR_W-1:0] PSUM_DEST = ADDR_MEM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PWIDTH-1:0] in_packet,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PWIDTH-1:0] out_packet,
    output logic              filter_loaded,
    output logic [7:0]        row_count,
    output logic              err_misroute,
    output logic              err_nofilt,
    output logic              busy
);

    localparam int SUM_W = 2 * DWIDTH + 2;

    state_e              state;
    state_e              state_next;
    logic [DWIDTH-1:0]   filt [0:2];
    logic [DWIDTH-1:0]   pix  [0:4];
    logic [1:0]          col;
    logic [DWIDTH-1:0]   tap_p0;
    logic [DWIDTH-1:0]   tap_p1;
    logic [DWIDTH-1:0]   tap_p2;
    logic [SUM_W-1:0]    mac_sum;
    logic [PWIDTH-1:0]   result;

    logic [ADDR_W-1:0]    pkt_dest;
    pkt_kind_e            pkt_kind;
    logic [PAYLOAD_W-1:0] payload;
    logic                 accept;
    logic                 addr_hit;
    logic                 row_start;
    logic                 unused_src;

    assign pkt_dest   = in_packet[DEST_HI:DEST_LO];
    assign pkt_kind   = pkt_kind_e'(in_packet[KIND_BIT]);
    assign payload    = in_packet[PAYLOAD_W-1:0];
    assign unused_src = ^in_packet[SRC_HI:SRC_LO];

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign addr_hit  = (pkt_dest == MY_ADDR);
    assign row_start = accept && addr_hit && (pkt_kind == PKT_PIXEL) && filter_loaded;

    // Sliding three-pixel window over the latched row, selected by column.
    always_comb begin
        tap_p0 = pix[0];
        tap_p1 = pix[1];
        tap_p2 = pix[2];
        case (col)
            2'd1: begin
                tap_p0 = pix[1];
                tap_p1 = pix[2];
                tap_p2 = pix[3];
            end
            2'd2: begin
                tap_p0 = pix[2];
                tap_p1 = pix[3];
                tap_p2 = pix[4];
            end
            default: ;
        endcase
    end

    pe_mac3 #(
        .DWIDTH (DWIDTH),
        .SUM_W  (SUM_W)
    ) u_mac (
        .p0  (tap_p0),
        .p1  (tap_p1),
        .p2  (tap_p2),
        .f0  (filt[0]),
        .f1  (filt[1]),
        .f2  (filt[2]),
        .sum (mac_sum)
    );

    assign result = {1'b1, PSUM_DEST, MY_ADDR, row_count, 6'b0, col, 6'b0, mac_sum};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (row_start) state_next = COMPUTE;
            COMPUTE: state_next = EMIT;
            EMIT:    if (out_ready) state_next = (col == 2'd2) ? IDLE : COMPUTE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            col           <= 2'd0;
            out_valid     <= 1'b0;
            out_packet    <= '0;
            filter_loaded <= 1'b0;
            row_count     <= 8'd0;
            err_misroute  <= 1'b0;
            err_nofilt    <= 1'b0;
            for (int i = 0; i < 3; i++) filt[i] <= '0;
            for (int i = 0; i < 5; i++) pix[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!addr_hit) begin
                            err_misroute <= 1'b1;
                        end else if (pkt_kind == PKT_FILTER) begin
                            for (int i = 0; i < 3; i++)
                                filt[i] <= payload[DWIDTH*(2-i) +: DWIDTH];
                            filter_loaded <= 1'b1;
                        end else if (!filter_loaded) begin
                            err_nofilt <= 1'b1;
                        end else begin
                            for (int i = 0; i < 5; i++)
                                pix[i] <= payload[DWIDTH*(4-i) +: DWIDTH];
                            col <= 2'd0;
                        end
                    end
                end
                COMPUTE: begin
                    out_packet <= result;
                    out_valid  <= 1'b1;
                end
                EMIT: begin
                    // out_valid drops between columns so every result is a distinct transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (col == 2'd2) row_count <= row_count + 8'd1;
                        else             col       <= col + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// tb/tb_pe_noc_endpoint.sv - directed self-checking bench for pe_noc_endpoint
module tb_pe_noc_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [46:0] in_packet;
    logic        out_valid;
    logic        out_ready;
    logic [46:0] out_packet;
    logic        filter_loaded;
    logic [7:0]  row_count;
    logic        err_misroute;
    logic        err_nofilt;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  rows     = 8'd0;

    localparam logic [46:0] FILT_123  = {1'b0, 3'b011, 3'b110, 16'h00FF, 24'h010203};
    localparam logic [46:0] FILT_211  = {1'b0, 3'b011, 3'b110, 16'h0000, 24'h020101};
    localparam logic [46:0] FILT_FF   = {1'b0, 3'b011, 3'b110, 16'h0000, 24'hFFFFFF};
    localparam logic [46:0] FILT_MIS  = {1'b0, 3'b001, 3'b110, 16'h0000, 24'h090909};
    localparam logic [46:0] PIX_12345 = {1'b1, 3'b011, 3'b110, 40'h0102030405};
    localparam logic [46:0] PIX_TENS  = {1'b1, 3'b011, 3'b110, 40'h0A141E2832};
    localparam logic [46:0] PIX_FF    = {1'b1, 3'b011, 3'b110, 40'hFFFFFFFFFF};

    always #5 clk = ~clk;

    pe_noc_endpoint dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_packet     (in_packet),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_packet    (out_packet),
        .filter_loaded (filter_loaded),
        .row_count     (row_count),
        .err_misroute  (err_misroute),
        .err_nofilt    (err_nofilt),
        .busy          (busy)
    );

    function automatic logic [46:0] exp_pkt(input logic [7:0] row, input logic [1:0] c,
                                            input logic [17:0] raw);
        logic [17:0] s;
`ifdef PE_PSUM_CLIP_EN
        s = (raw > 18'd255) ? 18'd255 : raw;
`else
        s = raw;
`endif
        return {1'b1, 3'b110, 3'b011, row, 6'b0, c, 6'b0, s};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rows  = 8'd0;
    endtask

    // Presents a packet for one cycle; caller guarantees the endpoint is idle.
    task automatic send_pkt(input logic [46:0] p);
        in_packet = p;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, out_valid, filter_loaded, err_misroute, err_nofilt, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/ov/fl/mis/nof/busy=%b expected 100000",
                     {in_ready, out_valid, filter_loaded, err_misroute, err_nofilt, busy});
        end
        n_checks++;
        if (row_count !== 8'd0 || out_packet !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got row_count=%0d out_packet=%h expected 0 and 0", row_count, out_packet);
        end
    endtask

    task automatic test_basic_row();
        logic [17:0] ps [3] = '{18'd14, 18'd20, 18'd26};
        send_pkt(FILT_123);
        n_checks++;
        if (filter_loaded !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_filter_load: got fl=%b rdy=%b busy=%b expected 1 1 0", filter_loaded, in_ready, busy);
        end
        in_packet = PIX_12345;
        in_valid  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (in_ready !== 1'(k == 7) || out_valid !== 1'(k % 2 == 0)) begin
                n_fail++;
                $display("FAIL basic_timing_T+%0d: got in_ready=%b out_valid=%b expected %b %b",
                         k, in_ready, out_valid, 1'(k == 7), 1'(k % 2 == 0));
            end
            if (k % 2 == 0) begin
                n_checks++;
                if (out_packet !== exp_pkt(rows, 2'(k / 2 - 1), ps[k / 2 - 1])) begin
                    n_fail++;
                    $display("FAIL basic_col%0d: got %h expected %h", k / 2 - 1, out_packet,
                             exp_pkt(rows, 2'(k / 2 - 1), ps[k / 2 - 1]));
                end
            end
        end
        rows++;
        n_checks++;
        if (row_count !== rows) begin
            n_fail++;
            $display("FAIL basic_row_count: got %0d expected %0d", row_count, rows);
        end
    endtask

    task automatic test_nofilt();
        logic [17:0] ps [3] = '{18'd70, 18'd110, 18'd150};
        logic        seen = 1'b0;
        do_reset();
        send_pkt(PIX_TENS);
        n_checks++;
        if (err_nofilt !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || err_misroute !== 1'b0) begin
            n_fail++;
            $display("FAIL nofilt_drop: got nof=%b rdy=%b busy=%b mis=%b expected 1 1 0 0",
                     err_nofilt, in_ready, busy, err_misroute);
        end
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL nofilt_no_output: got out_valid seen=%b expected 0", seen);
        end
        send_pkt(FILT_211);
        send_pkt(PIX_TENS);
        for (int c = 0; c < 3; c++) begin
            for (int w = 0; w < 8 && out_valid !== 1'b1; w++) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_packet !== exp_pkt(rows, 2'(c), ps[c])) begin
                n_fail++;
                $display("FAIL nofilt_recover_col%0d: got valid=%b pkt=%h expected valid=1 pkt=%h",
                         c, out_valid, out_packet, exp_pkt(rows, 2'(c), ps[c]));
            end
            @(negedge clk);
        end
        rows++;
        n_checks++;
        if (err_nofilt !== 1'b1) begin
            n_fail++;
            $display("FAIL nofilt_sticky: got %b expected 1", err_nofilt);
        end
    endtask

    task automatic test_misroute();
        logic [17:0] ps [3] = '{18'd7, 18'd11, 18'd15};
        do_reset();
        send_pkt(FILT_MIS);
        n_checks++;
        if (err_misroute !== 1'b1 || filter_loaded !== 1'b0 || err_nofilt !== 1'b0) begin
            n_fail++;
            $display("FAIL misroute_drop: got mis=%b fl=%b nof=%b expected 1 0 0",
                     err_misroute, filter_loaded, err_nofilt);
        end
        send_pkt(FILT_211);
        send_pkt(FILT_MIS);
        send_pkt(PIX_12345);
        for (int c = 0; c < 3; c++) begin
            for (int w = 0; w < 8 && out_valid !== 1'b1; w++) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_packet !== exp_pkt(rows, 2'(c), ps[c])) begin
                n_fail++;
                $display("FAIL misroute_filter_kept_col%0d: got valid=%b pkt=%h expected valid=1 pkt=%h",
                         c, out_valid, out_packet, exp_pkt(rows, 2'(c), ps[c]));
            end
            @(negedge clk);
        end
        rows++;
    endtask

    task automatic test_max_values();
        send_pkt(FILT_FF);
        send_pkt(PIX_FF);
        for (int c = 0; c < 3; c++) begin
            for (int w = 0; w < 8 && out_valid !== 1'b1; w++) @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_packet !== exp_pkt(rows, 2'(c), 18'h2FA03)) begin
                n_fail++;
                $display("FAIL max_col%0d: got valid=%b pkt=%h expected valid=1 pkt=%h",
                         c, out_valid, out_packet, exp_pkt(rows, 2'(c), 18'h2FA03));
            end
            @(negedge clk);
        end
        rows++;
    endtask

    task automatic test_backpressure();
        logic [46:0] held;
        send_pkt(FILT_123);
        send_pkt(PIX_12345);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_packet !== exp_pkt(rows, 2'd0, 18'd14)) begin
            n_fail++;
            $display("FAIL bp_col0: got valid=%b pkt=%h expected valid=1 pkt=%h",
                     out_valid, out_packet, exp_pkt(rows, 2'd0, 18'd14));
        end
        @(negedge clk);
        @(negedge clk);
        held = exp_pkt(rows, 2'd1, 18'd20);
        n_checks++;
        if (out_valid !== 1'b1 || out_packet !== held) begin
            n_fail++;
            $display("FAIL bp_col1: got valid=%b pkt=%h expected valid=1 pkt=%h", out_valid, out_packet, held);
        end
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_packet !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got valid=%b pkt=%h rdy=%b expected 1 %h 0",
                         i, out_valid, out_packet, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release_gap: got out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_packet !== exp_pkt(rows, 2'd2, 18'd26)) begin
            n_fail++;
            $display("FAIL bp_col2: got valid=%b pkt=%h expected valid=1 pkt=%h",
                     out_valid, out_packet, exp_pkt(rows, 2'd2, 18'd26));
        end
        @(negedge clk);
        rows++;
        n_checks++;
        if (in_ready !== 1'b1 || row_count !== rows) begin
            n_fail++;
            $display("FAIL bp_done: got in_ready=%b row_count=%0d expected 1 %0d", in_ready, row_count, rows);
        end
    endtask

    task automatic test_reset_mid_row();
        logic seen = 1'b0;
        send_pkt(FILT_MIS);
        send_pkt(PIX_12345);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || err_misroute !== 1'b1 || row_count !== rows) begin
            n_fail++;
            $display("FAIL midrow_pre: got busy=%b ov=%b mis=%b rc=%0d expected 1 0 1 %0d",
                     busy, out_valid, err_misroute, row_count, rows);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rows  = 8'd0;
        n_checks++;
        if ({busy, in_ready, out_valid, filter_loaded, err_misroute, err_nofilt} !== 6'b010000
            || row_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midrow_reset: got busy/rdy/ov/fl/mis/nof=%b rc=%0d expected 010000 0",
                     {busy, in_ready, out_valid, filter_loaded, err_misroute, err_nofilt}, row_count);
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid || busy) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrow_no_partial: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_row();
        test_nofilt();
        test_misroute();
        test_max_values();
        test_backpressure();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
